// File: rtl/SDRAM_PKG.sv
// Shared types for the SDRAM arbiter: line address and beat data.
package SDRAM_PKG;

  typedef logic [23:0] dram_access_t;
  typedef logic [31:0] data_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the cache ports, the arbiter and the SDRAM controller.
// master: arbiter view. slave: cache ports plus controller.
interface sdram_arbiter_if #(
  parameter int N_SRC = 4
);

  logic [N_SRC-1:0]                         SRC_REQ_IN;
  logic [N_SRC-1:0]                         SRC_WRITE_IN;
  SDRAM_PKG::dram_access_t [N_SRC-1:0]      SRC_ACS_IN;
  SDRAM_PKG::data_t [N_SRC-1:0]             SRC_WDATA_IN;
  logic [N_SRC-1:0]                         SRC_ACK_OUT;
  logic [N_SRC-1:0]                         SRC_BEAT_OUT;
  SDRAM_PKG::data_t                         SRC_RDATA_OUT;

  logic                                     DRAM_REQ_OUT;
  logic                                     DRAM_WRITE_OUT;
  SDRAM_PKG::dram_access_t                  DRAM_ACS_OUT;
  SDRAM_PKG::data_t                         DRAM_WDATA_OUT;
  logic                                     DRAM_ACK_IN;
  logic                                     DRAM_BEAT_IN;
  SDRAM_PKG::data_t                         DRAM_RDATA_IN;

  modport master (
    input  SRC_REQ_IN, SRC_WRITE_IN, SRC_ACS_IN, SRC_WDATA_IN,
    input  DRAM_ACK_IN, DRAM_BEAT_IN, DRAM_RDATA_IN,
    output SRC_ACK_OUT, SRC_BEAT_OUT, SRC_RDATA_OUT,
    output DRAM_REQ_OUT, DRAM_WRITE_OUT, DRAM_ACS_OUT, DRAM_WDATA_OUT
  );

  modport slave (
    output SRC_REQ_IN, SRC_WRITE_IN, SRC_ACS_IN, SRC_WDATA_IN,
    output DRAM_ACK_IN, DRAM_BEAT_IN, DRAM_RDATA_IN,
    input  SRC_ACK_OUT, SRC_BEAT_OUT, SRC_RDATA_OUT,
    input  DRAM_REQ_OUT, DRAM_WRITE_OUT, DRAM_ACS_OUT, DRAM_WDATA_OUT
  );

endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between N_SRC
// cache line-fill/writeback ports. A grant is held for a whole BURST-beat line.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transfer; pick next requester from rr_ptr upward
// ISSUE | command presented to controller, waiting for DRAM_ACK_IN
// XFER  | forwarding BURST beats between controller and granted port
module sdram_arbiter #(
  parameter int N_SRC = 4,
  parameter int BURST = 8
) (
  input  logic            CLK,
  input  logic            RESET_IN,
  sdram_arbiter_if.master bus
);

  import SDRAM_PKG::*;

  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [GW-1:0] LAST_SRC  = GW'(N_SRC - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          write_q, write_d;
  dram_access_t  acs_q, acs_d;

  logic          any_req;
  logic [GW-1:0] pick;
  logic [GW:0]   idx;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    pick    = rr_ptr_q;
    idx     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (idx >= (GW+1)'(N_SRC)) begin
        idx = idx - (GW+1)'(N_SRC);
      end
      if (!any_req && bus.SRC_REQ_IN[idx[GW-1:0]]) begin
        any_req = 1'b1;
        pick    = idx[GW-1:0];
      end
    end
  end

  // State, grant, pointer and latched command registers.
  always_ff @(posedge CLK or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      write_q    <= 1'b0;
      acs_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      write_q    <= write_d;
      acs_q      <= acs_d;
    end
  end

  // Next-state logic and all outputs; ACK and beat strobes route combinationally
  // to the granted port only, data paths are gated to zero outside XFER.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    write_d    = write_q;
    acs_d      = acs_q;

    bus.DRAM_REQ_OUT   = 1'b0;
    bus.DRAM_WRITE_OUT = write_q;
    bus.DRAM_ACS_OUT   = acs_q;
    bus.DRAM_WDATA_OUT = '0;
    bus.SRC_ACK_OUT    = '0;
    bus.SRC_BEAT_OUT   = '0;
    bus.SRC_RDATA_OUT  = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          write_d = bus.SRC_WRITE_IN[pick];
          acs_d   = bus.SRC_ACS_IN[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.DRAM_REQ_OUT = 1'b1;
        if (bus.DRAM_ACK_IN) begin
          bus.SRC_ACK_OUT[grant_q] = 1'b1;
          beat_cnt_d               = '0;
          state_d                  = XFER;
        end
      end
      XFER: begin
        bus.DRAM_WDATA_OUT = bus.SRC_WDATA_IN[grant_q];
        bus.SRC_RDATA_OUT  = bus.DRAM_RDATA_IN;
        if (bus.DRAM_BEAT_IN) begin
          bus.SRC_BEAT_OUT[grant_q] = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            rr_ptr_d   = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: controller model plus a transaction scoreboard.
module tb_sdram_arbiter;

  import SDRAM_PKG::*;

  localparam int N_SRC = 4;
  localparam int BURST = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sdram_arbiter_if #(.N_SRC(N_SRC)) bus ();

  sdram_arbiter #(.N_SRC(N_SRC), .BURST(BURST)) dut (
    .CLK      (clk),
    .RESET_IN (rst_n),
    .bus      (bus)
  );

  typedef struct {
    int           port;
    logic         wr;
    dram_access_t acs;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   last_lat = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic wr, input dram_access_t acs);
    bus.SRC_REQ_IN[p]   = 1'b1;
    bus.SRC_WRITE_IN[p] = wr;
    bus.SRC_ACS_IN[p]   = acs;
    exp_q.push_back('{port: p, wr: wr, acs: acs});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   bus.DRAM_REQ_OUT, 0);
    chk({tag, "_write"}, bus.DRAM_WRITE_OUT, 0);
    chk({tag, "_acs"},   bus.DRAM_ACS_OUT, 0);
    chk({tag, "_wdata"}, bus.DRAM_WDATA_OUT, 0);
    chk({tag, "_ack"},   bus.SRC_ACK_OUT, 0);
    chk({tag, "_beat"},  bus.SRC_BEAT_OUT, 0);
    chk({tag, "_rdata"}, bus.SRC_RDATA_OUT, 0);
  endtask

  // Controller model: waits for a command, checks it against the scoreboard,
  // ACKs after ack_dly cycles, then delivers BURST beats (one gap cycle).
  // abort_at >= 0 pulls reset at that beat instead of finishing.
  task automatic serve(input int ack_dly, input bit stray, input bit rearm, input int abort_at);
    exp_t             e;
    int               cnt;
    logic [N_SRC-1:0] oh;
    data_t            rd;
    data_t            wd;
    bus.DRAM_BEAT_IN = 1'b0;
    bus.DRAM_ACK_IN  = 1'b0;
    cnt = 0;
    while (bus.DRAM_REQ_OUT !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("req_seen", bus.DRAM_REQ_OUT, 1);
    if (bus.DRAM_REQ_OUT !== 1'b1) return;
    last_lat = cnt;
    chk("sb_pending", exp_q.size() > 0, 1);
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    oh = N_SRC'(1) << e.port;
    chk("dram_write", bus.DRAM_WRITE_OUT, e.wr);
    chk("dram_acs", bus.DRAM_ACS_OUT, e.acs);
    for (int d = 0; d < ack_dly; d++) begin
      bus.DRAM_BEAT_IN = stray;
      #1;
      chk("issue_hold", bus.DRAM_REQ_OUT, 1);
      chk("issue_no_beat", bus.SRC_BEAT_OUT, 0);
      chk("issue_no_ack", bus.SRC_ACK_OUT, 0);
      tick();
    end
    bus.DRAM_BEAT_IN = 1'b0;
    bus.DRAM_ACK_IN  = 1'b1;
    #1;
    chk("src_ack", bus.SRC_ACK_OUT, oh);
    tick();
    bus.DRAM_ACK_IN           = 1'b0;
    bus.SRC_REQ_IN[e.port]    = 1'b0;
    #1;
    chk("req_drop", bus.DRAM_REQ_OUT, 0);
    chk("ack_once", bus.SRC_ACK_OUT, 0);
    for (int b = 0; b < BURST; b++) begin
      tick();
      if (b == 1 && rearm) drive_req(e.port, e.wr, e.acs);
      if (b == 3) begin
        bus.DRAM_BEAT_IN = 1'b0;
        #1;
        chk("gap_no_beat", bus.SRC_BEAT_OUT, 0);
        tick();
      end
      rd = $urandom | 32'h1;
      wd = e.wr ? data_t'(b) : data_t'(32'hA500_0000 + b);
      for (int p = 0; p < N_SRC; p++) begin
        bus.SRC_WDATA_IN[p] = (p == e.port) ? wd : data_t'(32'hFF00_0000 + p);
      end
      bus.DRAM_RDATA_IN = rd;
      if (b == abort_at) begin
        rst_n            = 1'b0;
        bus.DRAM_BEAT_IN = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick();
        chk("rst_hold_beat", bus.SRC_BEAT_OUT, 0);
        tick();
        rst_n            = 1'b1;
        bus.DRAM_BEAT_IN = 1'b0;
        return;
      end
      bus.DRAM_BEAT_IN = 1'b1;
      #1;
      chk("beat_strobe", bus.SRC_BEAT_OUT, oh);
      chk("rdata", bus.SRC_RDATA_OUT, rd);
      chk("wdata", bus.DRAM_WDATA_OUT, wd);
    end
    tick();
    bus.DRAM_BEAT_IN = 1'b1;
    #1;
    chk("idle_no_beat", bus.SRC_BEAT_OUT, 0);
    chk("idle_no_req", bus.DRAM_REQ_OUT, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SRC_REQ_IN    = '0;
    bus.SRC_WRITE_IN  = '0;
    bus.SRC_ACS_IN    = '0;
    bus.SRC_WDATA_IN  = '0;
    bus.DRAM_ACK_IN   = 1'b0;
    bus.DRAM_BEAT_IN  = 1'b0;
    bus.DRAM_RDATA_IN = 32'h5A5A_5A5A;

    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Stray beats while idle are not forwarded.
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.DRAM_BEAT_IN = 1'b1;
      #1;
      chk("idle_stray_beat", bus.SRC_BEAT_OUT, 0);
      chk("idle_stray_req", bus.DRAM_REQ_OUT, 0);
    end
    bus.DRAM_BEAT_IN = 1'b0;

    // Single read on port 2, ACK after 3 cycles, stray beats during ISSUE.
    tick();
    drive_req(2, 1'b0, 24'h00_2222);
    serve(3, 1'b1, 1'b0, -1);
    chk("issue_latency", last_lat, 1);

    // Ports 3 and 0 with rr_ptr=3: port 3 first, then wrap to 0.
    tick();
    drive_req(3, 1'b0, 24'h00_3030);
    drive_req(0, 1'b0, 24'h00_0303);
    serve(1, 1'b0, 1'b0, -1);
    serve(0, 1'b0, 1'b0, -1);

    // Port 1 write: write data equals beat index.
    tick();
    drive_req(1, 1'b1, 24'h00_1111);
    serve(2, 1'b0, 1'b0, -1);
    chk("sb_drain_1", exp_q.size(), 0);

    // Reset, then all four ports requesting continuously.
    tick();
    bus.DRAM_BEAT_IN = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive_req(0, 1'b0, 24'hB0_0000);
    drive_req(1, 1'b1, 24'hB0_0001);
    drive_req(2, 1'b0, 24'hB0_0002);
    drive_req(3, 1'b1, 24'hB0_0003);
    serve(1, 1'b0, 1'b1, -1);
    for (int i = 0; i < 4; i++) serve(1, 1'b0, 1'b0, -1);
    chk("sb_drain_2", exp_q.size(), 0);

    // Reset at beat 4 of a read; pending ports re-arbitrated from rr_ptr=0.
    tick();
    drive_req(1, 1'b0, 24'hE0_0001);
    drive_req(0, 1'b0, 24'hE0_0000);
    drive_req(2, 1'b1, 24'hE0_0002);
    serve(1, 1'b0, 1'b0, 4);
    serve(1, 1'b0, 1'b0, -1);
    serve(2, 1'b0, 1'b0, -1);
    chk("sb_drain_3", exp_q.size(), 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
